// File: rtl/lru_pkg.sv
// rtl/lru_pkg.sv - shared types and helpers for the LRU replacement logic
package lru_pkg;

  // Default geometry of the 2-way LRU store.
  localparam int LRU_DEFAULT_ENTRIES = 256;

  // Controller states: normal arbitration or a full-array clear sweep.
  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } lru_ctrl_state_e;

  // Set-index width for a power-of-two number of sets.
  function automatic int lru_index_bits(input int entries);
    return $clog2(entries);
  endfunction

endpackage

// File: rtl/lru2.sv
// rtl/lru2.sv - 2-way LRU bit store, one combinational read / clocked update port
module lru2
  import lru_pkg::*;
#(
  parameter int ENTRIES    = LRU_DEFAULT_ENTRIES,
  parameter int INDEX_BITS = lru_index_bits(ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] line_selector,
  input  logic                  lru_update,
  input  logic                  referenced_set,
  output logic                  lru_way
);

  // One bit per set naming the least-recently-used way.
  logic [ENTRIES-1:0] lru_q;

  // The referenced way becomes MRU, so the other way is now LRU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lru_q <= '0;
    end else if (lru_update) begin
      lru_q[line_selector] <= ~referenced_set;
    end
  end

  assign lru_way = lru_q[line_selector];

endmodule

// File: rtl/lru2_ctrl.sv
// rtl/lru2_ctrl.sv - arbitrates hit updates, victim allocation and flush onto the lru2 port
module lru2_ctrl
  import lru_pkg::*;
#(
  parameter int ENTRIES    = LRU_DEFAULT_ENTRIES,
  parameter int INDEX_BITS = lru_index_bits(ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hit_valid,
  input  logic [INDEX_BITS-1:0] hit_index,
  input  logic                  hit_way,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  input  logic [INDEX_BITS-1:0] alloc_index,
  output logic                  victim_valid,
  output logic                  victim_way,
  output logic [INDEX_BITS-1:0] victim_index,
  input  logic                  flush_req,
  output logic                  flush_busy
);

  localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(ENTRIES - 1);

  lru_ctrl_state_e       state_q, state_d;
  logic [INDEX_BITS-1:0] cnt_q, cnt_d;
  logic                  victim_valid_q, victim_valid_d;
  logic                  victim_way_q, victim_way_d;
  logic [INDEX_BITS-1:0] victim_index_q, victim_index_d;

  logic [INDEX_BITS-1:0] line_selector;
  logic                  lru_update;
  logic                  referenced_set;
  logic                  lru_way;

  lru2 #(
    .ENTRIES    (ENTRIES),
    .INDEX_BITS (INDEX_BITS)
  ) u_lru2 (
    .clk            (clk),
    .rst_n          (rst_n),
    .line_selector  (line_selector),
    .lru_update     (lru_update),
    .referenced_set (referenced_set),
    .lru_way        (lru_way)
  );

  // Allocation only yields to a same-cycle hit; it never looks at alloc_valid.
  assign alloc_ready = (state_q == IDLE) && !hit_valid;
  assign flush_busy  = (state_q == FLUSH);

  // Store-port arbitration, flush sequencing and victim response capture.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    line_selector  = '0;
    lru_update     = 1'b0;
    referenced_set = 1'b0;
    victim_valid_d = 1'b0;
    victim_way_d   = victim_way_q;
    victim_index_d = victim_index_q;

    case (state_q)
      IDLE: begin
        if (hit_valid) begin
          line_selector  = hit_index;
          lru_update     = 1'b1;
          referenced_set = hit_way;
        end else if (alloc_valid) begin
          // The current LRU way is the victim and is made MRU in the same access.
          line_selector  = alloc_index;
          lru_update     = 1'b1;
          referenced_set = lru_way;
          victim_valid_d = 1'b1;
          victim_way_d   = lru_way;
          victim_index_d = alloc_index;
        end
        if (flush_req) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end

      FLUSH: begin
        // Referencing way 1 leaves the stored bit at 0, matching the reset value.
        line_selector  = cnt_q;
        lru_update     = 1'b1;
        referenced_set = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and sweep counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered victim response, one-cycle valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      victim_valid_q <= 1'b0;
      victim_way_q   <= 1'b0;
      victim_index_q <= '0;
    end else begin
      victim_valid_q <= victim_valid_d;
      victim_way_q   <= victim_way_d;
      victim_index_q <= victim_index_d;
    end
  end

  assign victim_valid = victim_valid_q;
  assign victim_way   = victim_way_q;
  assign victim_index = victim_index_q;

endmodule

// File: doc/lru2_ctrl.md
# lru2_ctrl

Replacement controller for the 2-way set-associative caches. It owns the single read/update port of the 2-way LRU bit store (`lru2`) and shares that port between three requesters: hit-update traffic, victim-allocation requests and a full-array flush sweep. It returns the victim way for each miss allocation and marks that way most-recently-used in the same access.

## Interface
Parameters:
- ENTRIES, 256, number of sets tracked; power of two.
- INDEX_BITS, 8, set index width; equals log2(ENTRIES).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- hit_valid  in  1  cache hit observed this cycle; single-cycle, no handshake.
- hit_index  in  INDEX_BITS  set of the hit.
- hit_way  in  1  way that hit.
- alloc_valid  in  1  miss allocation request.
- alloc_ready  out  1  allocation accepted this cycle when alloc_valid is also high.
- alloc_index  in  INDEX_BITS  set needing a victim.
- victim_valid  out  1  single-cycle pulse; the victim response is valid.
- victim_way  out  1  way to evict.
- victim_index  out  INDEX_BITS  echo of the accepted alloc_index.
- flush_req  in  1  request to reset all LRU state; pulse.
- flush_busy  out  1  a flush sweep is in progress.

## Operation
- States: IDLE, FLUSH.
- IDLE arbitration, one store access per cycle, hit has priority over alloc:
  - hit_valid: the store port selects hit_index and updates with referenced_set=hit_way. The stored bit becomes ~hit_way.
  - else alloc_valid: the store port selects alloc_index. The controller reads lru_way combinationally as the victim V and updates with referenced_set=V, which makes V MRU.
- alloc_ready = (state==IDLE) && !hit_valid. It is combinational and must not depend on alloc_valid.
- Hits are never stalled. The hit port is always accepted in IDLE and is silently dropped in FLUSH.
- flush_req sampled in IDLE: that cycle's hit or alloc is still served, then the state moves to FLUSH.
- FLUSH: counter cnt runs 0..ENTRIES-1, one set per cycle. Each cycle selects cnt and updates with referenced_set=1, so the stored bit is 0. After cnt=ENTRIES-1 the state returns to IDLE and cnt returns to 0.
- flush_req while in FLUSH is ignored. It does not restart the sweep and is not queued.
- Back-to-back allocs or hits to the same set need no forwarding, because each update lands at the clock edge before the next combinational read.
- Reset, at any time including mid-flush: state=IDLE, cnt=0, all store bits 0, victim_valid=0, victim_way=0, victim_index=0, flush_busy=0. alloc_ready reads 1 whenever hit_valid=0.

## Timing
- Hit update: issued in cycle N, visible to a read in N+1.
- Alloc accepted in cycle N: victim_valid, victim_way and victim_index are registered and appear in N+1 for exactly one cycle. There is no backpressure on the response.
- Allocation throughput is one per cycle while hit_valid stays low.
- flush_req in cycle N (IDLE): flush_busy is high for cycles N+1..N+ENTRIES, and alloc_ready is low over the same cycles. In cycle N+ENTRIES+1 the state is IDLE and alloc_ready is 1.
- victim_valid is never asserted during FLUSH except for the response to an alloc accepted in cycle N, which appears in N+1.

## Structure
- A shared package (`lru_pkg`) holds the state enum `lru_ctrl_state_e` {IDLE, FLUSH}. The index-width derivation helper lives there too.
- The block instantiates the existing `lru2` as its sole sub-module, with ENTRIES and INDEX_BITS passed through. Its port mux (line_selector, lru_update, referenced_set) is driven by the arbitration logic.
- The flush counter and response registers are local.

## Test plan
- Reset, then alloc index 5 → victim_way=0 next cycle. A second alloc to index 5 → victim_way=1. A third → victim_way=0.
- hit_valid on index 9 with way 0, then alloc index 9 → victim_way=1. hit way 1 on index 9, then alloc → victim_way=0.
- hit_valid and alloc_valid together on the same cycle → alloc_ready=0 and the hit is applied. Alloc accepted the next cycle with the victim reflecting the hit.
- Set indices 0, 100 and 255 to 1 via hits with way 0. flush_req → flush_busy high exactly 256 cycles, alloc_ready low throughout. Allocs to 0, 100 and 255 afterwards → victim_way=0.
- Hits issued during FLUSH → no effect: post-flush allocs return victim 0. A second flush_req mid-sweep → sweep length unchanged.
- rst_n asserted at cnt=37 of a flush → flush_busy=0 and victim_valid=0 immediately. Alloc after release → victim_way=0 and alloc_ready=1.
